// File: rtl/usb_pkg.sv
// Shared types and constants for the USB word/byte sequencing controller.
// Optional RX timeout is enabled with `define USB_RX_TIMEOUT_EN (see usb_rx_assembler).
package usb_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_BYTES_DEF = 4;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    LAST = 2'd2
  } tx_state_t;

endpackage

// File: rtl/usb_rx_assembler.sv
// Collects MSB-first bytes from the USB deserializer into complete words.
// With USB_RX_TIMEOUT_EN defined, a partial word idle for RX_TIMEOUT cycles is discarded.
module usb_rx_assembler
  import usb_pkg::*;
#(
  parameter int WORD_BYTES = WORD_BYTES_DEF,
  parameter int RX_TIMEOUT = 1024,
  localparam int WORD_W    = BYTE_W * WORD_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  byte_t             rx_byte,
  input  logic              new_byte,
  output logic [WORD_W-1:0] stock_data,
  output logic              data_ready,
  output logic              rx_abort
);

  localparam int CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_BYTES - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d, base_cnt;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [WORD_W-1:0] stock_q, stock_d;
  logic              drdy_q, drdy_d;
  logic              tmo;

  function automatic logic [WORD_W-1:0] shift_in(input logic [WORD_W-1:0] w,
                                                  input byte_t b);
    return (w << BYTE_W) | WORD_W'(b);
  endfunction

`ifdef USB_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(RX_TIMEOUT + 1);

  logic [TMO_W-1:0] idle_q, idle_d;
  logic             abort_q;

  assign tmo = (cnt_q != '0) && (idle_q == TMO_W'(RX_TIMEOUT));

  always_comb begin
    idle_d = idle_q;
    if (new_byte || tmo) begin
      idle_d = '0;
    end else if (cnt_q != '0) begin
      idle_d = idle_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      idle_q  <= idle_d;
      abort_q <= tmo;
    end
  end

  assign rx_abort = abort_q;
`else
  assign tmo      = 1'b0;
  assign rx_abort = 1'b0;
`endif

  // A byte arriving in the timeout cycle starts a fresh word; stale bytes
  // left in asm_q are shifted out before that word can complete.
  assign base_cnt = tmo ? '0 : cnt_q;

  always_comb begin
    cnt_d   = base_cnt;
    asm_d   = asm_q;
    stock_d = stock_q;
    drdy_d  = 1'b0;
    if (new_byte) begin
      asm_d = shift_in(asm_q, rx_byte);
      if (base_cnt == LAST_IDX) begin
        stock_d = shift_in(asm_q, rx_byte);
        drdy_d  = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = base_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      asm_q   <= '0;
      stock_q <= '0;
      drdy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      stock_q <= stock_d;
      drdy_q  <= drdy_d;
    end
  end

  assign stock_data = stock_q;
  assign data_ready = drdy_q;

endmodule

// File: rtl/usb_word_ctrl.sv
// Word/byte sequencer between the core word interface and the USB byte serializer/deserializer.
// Define USB_RX_TIMEOUT_EN to discard stalled partial RX words after RX_TIMEOUT idle cycles.
module usb_word_ctrl
  import usb_pkg::*;
#(
  parameter int WORD_BYTES = WORD_BYTES_DEF,
  parameter int RX_TIMEOUT = 1024,
  localparam int WORD_W    = BYTE_W * WORD_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              output_ready,
  input  logic [WORD_W-1:0] average_data,
  output byte_t             tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  byte_t             rx_byte,
  input  logic              new_byte,
  output logic [WORD_W-1:0] stock_data,
  output logic              data_ready,
  output logic              tx_busy,
  output logic              tx_overrun,
  output logic              rx_abort
);

  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'((WORD_BYTES > 1) ? WORD_BYTES - 2 : 0);
  localparam tx_state_t FIRST_ST = (WORD_BYTES > 1) ? SEND : LAST;

  tx_state_t         state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              ovr_q, ovr_d;
  logic              last_done;

  assign last_done = (state_q == LAST) && tx_ready;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    ovr_d       = ovr_q;

    unique case (state_q)
      IDLE: begin
        if (output_ready) begin
          shift_d = average_data;
          idx_d   = '0;
          state_d = FIRST_ST;
        end
      end
      SEND: begin
        if (tx_ready) begin
          shift_d = shift_q << BYTE_W;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == PRE_LAST) begin
            state_d = LAST;
          end
        end
      end
      LAST: begin
        if (tx_ready) begin
          idx_d = '0;
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            state_d     = FIRST_ST;
          end else if (output_ready) begin
            // Empty hold and a word arriving as the last byte leaves: chain it directly.
            shift_d = average_data;
            state_d = FIRST_ST;
          end else begin
            shift_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (output_ready && (state_q != IDLE)) begin
      if (!hold_full_q && !last_done) begin
        hold_d      = average_data;
        hold_full_d = 1'b1;
      end else if (hold_full_q && last_done) begin
        hold_d      = average_data;
        hold_full_d = 1'b1;
      end else if (hold_full_q) begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      idx_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ovr_q       <= ovr_d;
    end
  end

  assign tx_byte    = shift_q[WORD_W-1 -: BYTE_W];
  assign tx_valid   = (state_q != IDLE);
  assign tx_busy    = (state_q != IDLE) || hold_full_q;
  assign tx_overrun = ovr_q;

  usb_rx_assembler #(
    .WORD_BYTES (WORD_BYTES),
    .RX_TIMEOUT (RX_TIMEOUT)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx_byte    (rx_byte),
    .new_byte   (new_byte),
    .stock_data (stock_data),
    .data_ready (data_ready),
    .rx_abort   (rx_abort)
  );

endmodule

// File: tb/tb_usb_word_ctrl.sv
// Scoreboard bench for usb_word_ctrl: directed scenarios plus randomized traffic against a
// queue-based model of the byte stream, word capacity and RX assembly (USB_RX_TIMEOUT_EN aware).
module tb_usb_word_ctrl;

  localparam int WB  = 4;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst, output_ready, tx_ready, new_byte;
  logic [31:0] average_data;
  logic [7:0]  rx_byte;
  logic [7:0]  tx_byte;
  logic        tx_valid, data_ready, tx_busy, tx_overrun, rx_abort;
  logic [31:0] stock_data;

  always #5 clk = ~clk;

  usb_word_ctrl #(.WORD_BYTES(WB), .RX_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .output_ready (output_ready),
    .average_data (average_data),
    .tx_byte      (tx_byte),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_byte      (rx_byte),
    .new_byte     (new_byte),
    .stock_data   (stock_data),
    .data_ready   (data_ready),
    .tx_busy      (tx_busy),
    .tx_overrun   (tx_overrun),
    .rx_abort     (rx_abort)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: pending TX bytes in send order, partial RX bytes, expected registered outputs.
  logic [7:0]  txq[$];
  logic [7:0]  part[$];
  logic        m_ovr = 1'b0, m_drdy = 1'b0, m_abort = 1'b0, m_after_rst = 1'b0;
  logic [31:0] m_stock = '0;
  int          gap = 0;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endfunction

  always @(negedge clk) begin
    int   occ;
    logic tmo;
    chk("tx_valid",   {31'd0, tx_valid},   {31'd0, txq.size() != 0});
    chk("tx_busy",    {31'd0, tx_busy},    {31'd0, txq.size() != 0});
    chk("tx_overrun", {31'd0, tx_overrun}, {31'd0, m_ovr});
    chk("data_ready", {31'd0, data_ready}, {31'd0, m_drdy});
    chk("stock_data", stock_data, m_stock);
    chk("rx_abort",   {31'd0, rx_abort},   {31'd0, m_abort});
    if (m_after_rst) chk("tx_byte_rst", {24'd0, tx_byte}, 32'd0);
    if (txq.size() != 0 && tx_ready) chk("tx_byte", {24'd0, tx_byte}, {24'd0, txq[0]});

    m_after_rst = 1'b0;
    if (rst) begin
      txq.delete();
      part.delete();
      m_ovr = 1'b0; m_drdy = 1'b0; m_abort = 1'b0; m_stock = '0; gap = 0;
      m_after_rst = 1'b1;
    end else begin
      if (txq.size() != 0 && tx_ready) void'(txq.pop_front());
      if (output_ready) begin
        occ = (txq.size() + WB - 1) / WB;
        if (occ < 2) begin
          for (int i = WB - 1; i >= 0; i--) txq.push_back(average_data[i*8 +: 8]);
        end else begin
          m_ovr = 1'b1;
        end
      end

      m_drdy  = 1'b0;
      m_abort = 1'b0;
`ifdef USB_RX_TIMEOUT_EN
      tmo = (part.size() != 0) && (gap == TMO);
`else
      tmo = 1'b0;
`endif
      if (tmo) begin
        part.delete();
        m_abort = 1'b1;
      end
      if (new_byte) begin
        part.push_back(rx_byte);
        gap = 0;
        if (part.size() == WB) begin
          m_stock = {part[0], part[1], part[2], part[3]};
          m_drdy  = 1'b1;
          part.delete();
        end
      end else if (part.size() != 0) begin
        gap++;
      end
    end
  end

  task automatic cyc(input logic orr, input logic [31:0] d, input logic tr,
                     input logic nb, input logic [7:0] rb);
    output_ready = orr;
    average_data = d;
    tx_ready     = tr;
    new_byte     = nb;
    rx_byte      = rb;
    @(posedge clk);
    #1;
  endtask

  task automatic rx_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) cyc(1'b0, 32'd0, 1'b1, 1'b1, w[i*8 +: 8]);
  endtask

  logic [3:0] pat;

  initial begin
    rst = 1'b1;
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 8'd0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;

    // Single word, serializer always ready.
    cyc(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 8'd0);
    repeat (6) cyc(1'b0, 32'd0, 1'b1, 1'b0, 8'd0);

    // Backpressure pattern 1,0,0,1.
    pat = 4'b1001;
    cyc(1'b1, 32'h01020304, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 32'd0, pat[3 - (i % 4)], 1'b0, 8'd0);

    // Hold register fill then overrun on the third word.
    cyc(1'b1, 32'hA0A1A2A3, 1'b0, 1'b0, 8'd0);
    cyc(1'b1, 32'hB0B1B2B3, 1'b0, 1'b0, 8'd0);
    cyc(1'b1, 32'hC0C1C2C3, 1'b0, 1'b0, 8'd0);
    repeat (2) cyc(1'b0, 32'd0, 1'b0, 1'b0, 8'd0);
    repeat (10) cyc(1'b0, 32'd0, 1'b1, 1'b0, 8'd0);

    // RX assembly.
    rx_word(32'h12345678);
    repeat (3) cyc(1'b0, 32'd0, 1'b1, 1'b0, 8'd0);

    // Reset in the middle of both a TX word and an RX word.
    cyc(1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 8'd0);
    cyc(1'b0, 32'd0, 1'b1, 1'b1, 8'h55);
    cyc(1'b0, 32'd0, 1'b1, 1'b1, 8'h66);
    rst = 1'b1;
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 8'd0);
    rst = 1'b0;
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 8'd0);
    rx_word(32'hAABBCCDD);
    repeat (3) cyc(1'b0, 32'd0, 1'b1, 1'b0, 8'd0);

    // Stalled partial word: byte arriving exactly at the timeout, then a long stall.
    cyc(1'b0, 32'd0, 1'b1, 1'b1, 8'h99);
    cyc(1'b0, 32'd0, 1'b1, 1'b1, 8'h98);
    repeat (TMO) cyc(1'b0, 32'd0, 1'b1, 1'b0, 8'd0);
    rx_word(32'h11223344);
    repeat (2) cyc(1'b0, 32'd0, 1'b1, 1'b0, 8'd0);
    cyc(1'b0, 32'd0, 1'b1, 1'b1, 8'h77);
    cyc(1'b0, 32'd0, 1'b1, 1'b1, 8'h76);
    repeat (TMO + 12) cyc(1'b0, 32'd0, 1'b1, 1'b0, 8'd0);
    rx_word(32'h55667788);
    repeat (2) cyc(1'b0, 32'd0, 1'b1, 1'b0, 8'd0);

    // Randomized traffic in segments of varying RX density.
    for (int seg = 0; seg < 40; seg++) begin
      automatic int dens = $urandom_range(0, 3);
      for (int c = 0; c < 80; c++) begin
        rst = ($urandom_range(0, 399) == 0);
        cyc(($urandom_range(0, 5) == 0), $urandom, ($urandom_range(0, 2) != 0),
            (int'($urandom_range(0, 3)) < dens), 8'($urandom));
      end
    end
    rst = 1'b0;
    repeat (20) cyc(1'b0, 32'd0, 1'b1, 1'b0, 8'd0);
    chk("tx_drained", txq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
